// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N:1 arbitrating word multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        SEL_EXT,
        SEL_FIXED,
        SEL_RR
    } sel_mode_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: picks the first requester at or after ptr,
// wrapping around, by scanning a doubled copy of the request vector.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int IDX_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  grant,
    output logic              grant_valid
);

    logic [2*NUM_IN-1:0] req_dbl;

    // Walk downward so the last hit written is the lowest position inside the ptr window.
    always_comb begin
        req_dbl     = {req, req};
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 2*NUM_IN - 1; i >= 0; i--) begin
            if (i >= int'(ptr) && i < int'(ptr) + NUM_IN && req_dbl[i]) begin
                grant_valid = 1'b1;
                grant       = (i >= NUM_IN) ? IDX_W'(i - NUM_IN) : IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/arb_mux_nx1_reg.sv
// N:1 word multiplexer with per-channel valid/ready, selectable arbitration mode
// and a registered output stage that sustains one word per cycle.
module arb_mux_nx1_reg
    import mux_pkg::*;
#(
    parameter int        NUM_IN = 8,
    parameter int        WIDTH  = 32,
    parameter sel_mode_e MODE   = SEL_EXT,
    parameter int        SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel
);

    if (NUM_IN < 2) begin : g_bad_num_in
        $error("arb_mux_nx1_reg: NUM_IN must be at least 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("arb_mux_nx1_reg: WIDTH must be at least 1");
    end

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] arb_ptr, arb_grant, grant;
    logic             arb_grant_valid, ext_valid, grant_valid, load;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d, grant_data;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    assign arb_ptr = (MODE == SEL_RR) ? ptr_q : '0;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (arb_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_grant_valid)
    );

    // Compare sel against each real channel so unused codes can never grant or index out of range.
    always_comb begin
        ext_valid = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k && in_valid[k]) begin
                ext_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant       = arb_grant;
        grant_valid = arb_grant_valid;
        if (MODE == SEL_EXT) begin
            grant       = sel;
            grant_valid = ext_valid;
        end
    end

    assign load = (!out_valid_q || out_ready) && grant_valid && !rst;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(grant) == k) begin
                in_ready[k] = load;
                grant_data  = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_sel_d   = grant;
            ptr_d       = (int'(grant) == NUM_IN - 1) ? '0 : grant + SEL_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: doc/arb_mux_nx1_reg.md
Name: arb_mux_nx1_reg

Overview:
- Parametrised N:1 word multiplexer with a per-channel valid/ready handshake and a registered output stage.
- Generalises the fixed 8:1 32-bit mux in channel count and width.
- Adds three select modes: external select, fixed priority and round-robin.
- Used in the pipeline to merge several producers (forwarding sources, writeback requesters, LSU/CSR responders) onto one registered consumer port.

Parameters:
- NUM_IN, 8, number of input channels; must be 2 or more.
- WIDTH, 32, data width per channel.
- MODE, SEL_EXT, selection mode from the package enum: SEL_EXT, SEL_FIXED, SEL_RR.
- SEL_W, $clog2(NUM_IN), select/index width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  SEL_W  channel select; used only when MODE=SEL_EXT.
- in_valid  in  NUM_IN  per-channel request; bit k belongs to channel k.
- in_ready  out  NUM_IN  per-channel accept; one-hot or zero.
- in_data  in  NUM_IN*WIDTH  flattened inputs; channel k is in_data[k*WIDTH +: WIDTH], so channel 0 is at the LSBs.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  registered selected word.
- out_sel  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer=0, so channel 0 has highest priority.
  - in_ready=0 while rst=1.
- Load condition: load = (!out_valid || out_ready) && grant_valid.
  - Output register loads on a clk edge when load=1.
  - Latency is 1 cycle from an accepted input to out_valid.
- Grant, combinational, at most one per cycle:
  - SEL_EXT: grant = sel if sel < NUM_IN and in_valid[sel]=1; otherwise no grant. An out-of-range sel never grants and never produces X.
  - SEL_FIXED: lowest-index channel with in_valid=1.
  - SEL_RR: first valid channel at or after ptr, wrapping modulo NUM_IN.
- in_ready[k] = load && (grant == k). in_ready depends combinationally on out_ready; there is no skid buffer.
- Transfer on channel k when in_valid[k] && in_ready[k]. On transfer: out_data <= channel k data, out_sel <= k, out_valid <= 1.
- Output handshake:
  - out_valid && out_ready with no new grant: out_valid <= 0; out_data and out_sel hold their last values.
  - out_valid && out_ready with a new grant in the same cycle: the register is replaced back-to-back, out_valid stays 1, no bubble. Full throughput is one word per cycle.
  - out_valid && !out_ready: out_data and out_sel are held stable, all in_ready=0, and the RR pointer is frozen.
- RR pointer: updates only on a transfer, ptr <= (k == NUM_IN-1) ? 0 : k+1. No update on idle cycles or stalled cycles.
- Input changes: in_valid may drop without a transfer; the arbiter re-evaluates every cycle and holds no lock.
- Reset mid-operation: an in-flight output word is discarded, out_valid=0 immediately (asynchronous), and the pointer returns to 0.
- Non-power-of-2 NUM_IN: unused encodings are never granted, and pointer wrap uses an explicit compare, not overflow.
- Elaboration: error on NUM_IN<2 or WIDTH<1.

Decomposition:
- Package mux_pkg holds:
  - enum sel_mode_e {SEL_EXT, SEL_FIXED, SEL_RR};
  - a function clog2_min1 for index widths.
- Sub-module rr_arbiter:
  - parameter NUM_IN;
  - inputs req, ptr; outputs grant index and grant_valid;
  - purely combinational double-width priority scan.
- The top level owns the pointer register, the output register and the handshake.
- For SEL_FIXED the top level drives rr_arbiter with ptr tied to 0.

Test Plan:
- Reset/idle: rst pulse while in_valid=8'hFF and out_ready=1 -> out_valid=0, out_data=0, in_ready=0 during reset; first word appears one cycle after release.
- SEL_EXT: sel=3, in_valid=8'h08, channel 3 data=32'hDEAD_BEEF -> in_ready=8'h08, next cycle out_data=32'hDEAD_BEEF and out_sel=3; then sel=3 with in_valid=0 -> no transfer.
- SEL_FIXED: in_valid=8'b1010_0100, out_ready=1 -> grants in order 2,5,7 as each channel drops its valid after its transfer.
- SEL_RR fairness: all 8 valid, out_ready=1, data=k+0x100 -> out_sel sequence 0,1,…,7,0 with no bubbles; out_data=0x100..0x107.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0, RR pointer unchanged; out_ready=1 -> drain and refill in the same cycle with out_valid held at 1.
- Boundary: NUM_IN=5, WIDTH=16 in SEL_EXT -> sel=6 never grants; SEL_RR wraps from channel 4 to 0; flattened data packing is verified for each channel.
